// File: rtl/vga_scan_controller_pkg.sv
// Shared VGA scan timing defaults and display_addr field layout, used by the
// scan controller and by any pixel source that decodes the scan address.
package vga_scan_controller_pkg;

    localparam int H_VISIBLE_DEF = 800;
    localparam int H_FRONT_DEF   = 56;
    localparam int H_SYNC_DEF    = 120;
    localparam int H_BACK_DEF    = 64;

    localparam int V_VISIBLE_DEF = 600;
    localparam int V_FRONT_DEF   = 37;
    localparam int V_SYNC_DEF    = 6;
    localparam int V_BACK_DEF    = 23;

    localparam int H_COUNT_W     = 11;
    localparam int V_COUNT_W     = 10;

    localparam int ADDR_W        = 22;
    localparam int ADDR_FIELD_W  = 10;

    // Bit layout of display_addr, MSB first: [21] active, [20] zero, [19:10] x, [9:0] y.
    typedef struct packed {
        logic                    active;
        logic                    reserved;
        logic [ADDR_FIELD_W-1:0] x;
        logic [ADDR_FIELD_W-1:0] y;
    } scan_addr_t;

    function automatic logic [ADDR_W-1:0] pack_scan_addr(
        input logic                    active,
        input logic [ADDR_FIELD_W-1:0] x,
        input logic [ADDR_FIELD_W-1:0] y
    );
        scan_addr_t a;
        a.active   = active;
        a.reserved = 1'b0;
        a.x        = x;
        a.y        = y;
        return a;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: a wrapping position counter with visible-region and sync-pulse
// decodes. The horizontal instance counts every clock, the vertical one on line wrap.
module vga_axis_counter #(
    parameter int VISIBLE = 800,
    parameter int FRONT   = 56,
    parameter int SYNC    = 120,
    parameter int BACK    = 64,
    parameter int W       = 11
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    output logic [W-1:0] o_count,
    output logic         o_wrap,
    output logic         o_active,
    output logic         o_sync
);

    localparam int           TOTAL      = VISIBLE + FRONT + SYNC + BACK;
    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] VIS_END    = W'(VISIBLE);
    localparam logic [W-1:0] SYNC_START = W'(VISIBLE + FRONT);
    localparam logic [W-1:0] SYNC_END   = W'(VISIBLE + FRONT + SYNC);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign o_count  = r_count;
    assign o_wrap   = i_inc && (r_count == LAST);
    assign o_active = (r_count < VIS_END);
    // Sync window sits immediately after the front porch.
    assign o_sync   = (r_count >= SYNC_START) && (r_count < SYNC_END);

endmodule

// File: rtl/vga_scan_controller.sv
// VGA raster scan: publishes the current scan address to a combinational pixel
// source and registers colour, syncs and frame_start one clock behind it.
module vga_scan_controller
    import vga_scan_controller_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic [2:0]        display_data,
    output logic [ADDR_W-1:0] display_addr,
    output logic              vga_r,
    output logic              vga_g,
    output logic              vga_b,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              frame_start
);

    logic [H_COUNT_W-1:0] w_h_count;
    logic [V_COUNT_W-1:0] w_v_count;
    logic                 w_h_wrap;
    logic                 w_v_wrap;
    logic                 w_h_active;
    logic                 w_v_active;
    logic                 w_h_sync;
    logic                 w_v_sync;
    logic                 w_video_active;

    logic [2:0]           r_rgb;
    logic                 r_hsync;
    logic                 r_vsync;
    logic                 r_frame_start;
    logic                 r_at_origin;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .W       (H_COUNT_W)
    ) u_h_axis (
        .i_clk    (sysclk),
        .i_rst    (rst),
        .i_inc    (1'b1),
        .o_count  (w_h_count),
        .o_wrap   (w_h_wrap),
        .o_active (w_h_active),
        .o_sync   (w_h_sync)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .W       (V_COUNT_W)
    ) u_v_axis (
        .i_clk    (sysclk),
        .i_rst    (rst),
        .i_inc    (w_h_wrap),
        .o_count  (w_v_count),
        .o_wrap   (w_v_wrap),
        .o_active (w_v_active),
        .o_sync   (w_v_sync)
    );

    // The x field only holds 10 bits, so x >= 1024 must never read as active.
    assign w_video_active = w_h_active && w_v_active && !w_h_count[H_COUNT_W-1];

    assign display_addr = pack_scan_addr(w_video_active,
                                         w_h_count[ADDR_FIELD_W-1:0],
                                         w_v_count);

    // Counters sit at (0,0) exactly after a reset edge or a full-frame wrap,
    // so r_at_origin tracks that without a wide compare.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_rgb         <= 3'b000;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_frame_start <= 1'b0;
            r_at_origin   <= 1'b1;
        end else begin
            r_rgb         <= w_video_active ? display_data : 3'b000;
            r_hsync       <= w_h_sync;
            r_vsync       <= w_v_sync;
            r_frame_start <= r_at_origin;
            r_at_origin   <= w_v_wrap;
        end
    end

    assign vga_r       = r_rgb[2];
    assign vga_g       = r_rgb[1];
    assign vga_b       = r_rgb[0];
    assign vga_hsync   = r_hsync;
    assign vga_vsync   = r_vsync;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller: a default-geometry instance plus a tiny-geometry
// instance so whole frames fit in a short run, both checked against a position model.
module tb_vga_scan_controller;
    import vga_scan_controller_pkg::*;

    typedef struct {
        int hv; int hf; int hs; int hb;
        int vv; int vf; int vs; int vb;
    } geo_t;

    typedef struct {
        int         h;
        int         v;
        logic [2:0] data;
        logic       exp_act;
        logic [2:0] exp_rgb;
        logic       exp_hs;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_0 = 1'b1, rst_1 = 1'b1;
    logic [2:0]  d_0 = 3'b000, d_1 = 3'b000;
    logic [21:0] addr_0, addr_1;
    logic        r_0, g_0, b_0, hs_0, vs_0, fs_0;
    logic        r_1, g_1, b_1, hs_1, vs_1, fs_1;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  mh [2];
    int  mv [2];
    bit  mvalid [2];
    bit  rr0_en = 1'b0;
    bit  rr1_en = 1'b0;
    vec_t vecs [12];

    vga_scan_controller u_dut0 (
        .sysclk (clk), .rst (rst_0), .display_data (d_0), .display_addr (addr_0),
        .vga_r (r_0), .vga_g (g_0), .vga_b (b_0),
        .vga_hsync (hs_0), .vga_vsync (vs_0), .frame_start (fs_0)
    );

    vga_scan_controller #(
        .H_VISIBLE (10), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_VISIBLE (6),  .V_FRONT (1), .V_SYNC (2), .V_BACK (1)
    ) u_dut1 (
        .sysclk (clk), .rst (rst_1), .display_data (d_1), .display_addr (addr_1),
        .vga_r (r_1), .vga_g (g_1), .vga_b (b_1),
        .vga_hsync (hs_1), .vga_vsync (vs_1), .frame_start (fs_1)
    );

    function automatic geo_t geo_of(input int i);
        geo_t g;
        if (i == 0) g = '{H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF,
                          V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF};
        else        g = '{10, 2, 3, 2, 6, 1, 2, 1};
        return g;
    endfunction

    function automatic logic [21:0] model_addr(input int i);
        geo_t       g;
        logic       act;
        logic [9:0] hx;
        logic [9:0] vy;
        g   = geo_of(i);
        act = (mh[i] < g.hv) && (mv[i] < g.vv);
        hx  = 10'(mh[i] % 1024);
        vy  = 10'(mv[i]);
        return {act, 1'b0, hx, vy};
    endfunction

    function automatic logic [21:0] get_addr(input int i);
        return (i == 0) ? addr_0 : addr_1;
    endfunction
    function automatic logic [2:0] get_rgb(input int i);
        return (i == 0) ? {r_0, g_0, b_0} : {r_1, g_1, b_1};
    endfunction
    function automatic logic get_hs(input int i);
        return (i == 0) ? hs_0 : hs_1;
    endfunction
    function automatic logic get_vs(input int i);
        return (i == 0) ? vs_0 : vs_1;
    endfunction
    function automatic logic get_fs(input int i);
        return (i == 0) ? fs_0 : fs_1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock for both instances: check address before the edge, registered
    // outputs after it, then advance the reference positions.
    task automatic step(input logic ra, input logic [2:0] da, input logic rb, input logic [2:0] db);
        logic       rr [2];
        logic [2:0] dd [2];
        logic [2:0] e_rgb [2];
        logic       e_hs [2];
        logic       e_vs [2];
        logic       e_fs [2];
        logic       chk [2];
        logic       act;
        geo_t       g;
        rr[0] = ra; rr[1] = rb; dd[0] = da; dd[1] = db;
        rst_0 = ra; d_0 = da; rst_1 = rb; d_1 = db;
        #1;
        for (int i = 0; i < 2; i++) begin
            g      = geo_of(i);
            chk[i] = mvalid[i] || rr[i];
            if (mvalid[i]) check(i == 0 ? "addr0" : "addr1", 32'(get_addr(i)), 32'(model_addr(i)));
            if (rr[i]) begin
                e_rgb[i] = 3'b000; e_hs[i] = 1'b0; e_vs[i] = 1'b0; e_fs[i] = 1'b0;
            end else begin
                act      = (mh[i] < g.hv) && (mv[i] < g.vv);
                e_rgb[i] = act ? dd[i] : 3'b000;
                e_hs[i]  = (mh[i] >= g.hv + g.hf) && (mh[i] < g.hv + g.hf + g.hs);
                e_vs[i]  = (mv[i] >= g.vv + g.vf) && (mv[i] < g.vv + g.vf + g.vs);
                e_fs[i]  = (mh[i] == 0) && (mv[i] == 0);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            g = geo_of(i);
            if (chk[i]) begin
                check(i == 0 ? "rgb0" : "rgb1", 32'(get_rgb(i)), 32'(e_rgb[i]));
                check(i == 0 ? "hsync0" : "hsync1", 32'(get_hs(i)), 32'(e_hs[i]));
                check(i == 0 ? "vsync0" : "vsync1", 32'(get_vs(i)), 32'(e_vs[i]));
                check(i == 0 ? "fstart0" : "fstart1", 32'(get_fs(i)), 32'(e_fs[i]));
            end
            if (rr[i]) begin
                mh[i] = 0; mv[i] = 0; mvalid[i] = 1'b1;
            end else if (mvalid[i]) begin
                mh[i] = mh[i] + 1;
                if (mh[i] == g.hv + g.hf + g.hs + g.hb) begin
                    mh[i] = 0;
                    mv[i] = mv[i] + 1;
                    if (mv[i] == g.vv + g.vf + g.vs + g.vb) mv[i] = 0;
                end
            end
        end
    endtask

    task automatic rand_step();
        logic ra, rb;
        ra = rr0_en && ($urandom_range(0, 499) == 0);
        rb = rr1_en && ($urandom_range(0, 49) == 0);
        step(ra, 3'($urandom), rb, 3'($urandom));
    endtask

    task automatic run_to(input int i, input int h, input int v);
        int n;
        n = 0;
        while (!(mh[i] == h && mv[i] == v) && n < 5000) begin
            rand_step();
            n++;
        end
        check("run_to_reached", 32'(mh[i] == h && mv[i] == v), 32'd1);
    endtask

    initial begin
        int fs_cnt, vs_cnt, hs_cnt, first_h, first_v, n111, n000;
        logic [9:0] hx, vy;
        logic [2:0] dd;

        vecs[0]  = '{3,    0, 3'b101, 1'b1, 3'b101, 1'b0};
        vecs[1]  = '{799,  0, 3'b110, 1'b1, 3'b110, 1'b0};
        vecs[2]  = '{800,  0, 3'b111, 1'b0, 3'b000, 1'b0};
        vecs[3]  = '{855,  0, 3'b111, 1'b0, 3'b000, 1'b0};
        vecs[4]  = '{856,  0, 3'b111, 1'b0, 3'b000, 1'b1};
        vecs[5]  = '{975,  0, 3'b010, 1'b0, 3'b000, 1'b1};
        vecs[6]  = '{976,  0, 3'b111, 1'b0, 3'b000, 1'b0};
        vecs[7]  = '{1023, 0, 3'b111, 1'b0, 3'b000, 1'b0};
        vecs[8]  = '{1024, 0, 3'b111, 1'b0, 3'b000, 1'b0};
        vecs[9]  = '{1039, 0, 3'b111, 1'b0, 3'b000, 1'b0};
        vecs[10] = '{0,    1, 3'b011, 1'b1, 3'b011, 1'b0};
        vecs[11] = '{1,    1, 3'b111, 1'b1, 3'b111, 1'b0};

        // Reset held three clocks, then release.
        for (int k = 0; k < 3; k++) step(1'b1, 3'($urandom), 1'b1, 3'($urandom));
        check("rst_addr0", 32'(addr_0), 32'h0020_0000);
        check("rst_addr1", 32'(addr_1), 32'h0020_0000);
        check("rst_rgb0", 32'({r_0, g_0, b_0}), 32'd0);
        check("rst_fs0", 32'(fs_0), 32'd0);
        step(1'b0, 3'($urandom), 1'b0, 3'($urandom));
        check("rel_fs0", 32'(fs_0), 32'd1);
        check("rel_fs1", 32'(fs_1), 32'd1);
        step(1'b0, 3'($urandom), 1'b0, 3'($urandom));
        check("rel_fs0_once", 32'(fs_0), 32'd0);

        // Table of scan positions on the default-geometry instance.
        rr1_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            run_to(0, vecs[k].h, vecs[k].v);
            hx = 10'(vecs[k].h);
            vy = 10'(vecs[k].v);
            check("vec_addr", 32'(addr_0), 32'({vecs[k].exp_act, 1'b0, hx, vy}));
            step(1'b0, vecs[k].data, 1'b0, 3'($urandom));
            check("vec_rgb", 32'({r_0, g_0, b_0}), 32'(vecs[k].exp_rgb));
            check("vec_hsync", 32'(hs_0), 32'(vecs[k].exp_hs));
        end
        rr1_en = 1'b0;

        // One full line: hsync width and position, v advances by one.
        run_to(0, 0, 2);
        hs_cnt = 0; first_h = -1;
        for (int k = 0; k < 1040; k++) begin
            int ph;
            ph = mh[0];
            step(1'b0, 3'($urandom), 1'b0, 3'($urandom));
            if (hs_0) begin
                hs_cnt++;
                if (first_h < 0) first_h = ph;
            end
        end
        check("line_hs_width", 32'(hs_cnt), 32'd120);
        check("line_hs_first", 32'(first_h), 32'd856);
        check("line_wrap_addr", 32'(addr_0), 32'h0020_0003);

        // Latency: pixel source returns {x[0], y[0], 1} for the presented address.
        for (int k = 0; k < 6; k++) begin
            dd = {addr_0[10], addr_0[0], 1'b1};
            step(1'b0, dd, 1'b0, 3'($urandom));
            if (k == 4) check("lat_rgb_4_3", 32'({r_0, g_0, b_0}), 32'b011);
            if (k == 5) check("lat_rgb_5_3", 32'({r_0, g_0, b_0}), 32'b111);
        end

        // Two whole frames on the small instance straight out of reset.
        step(1'b0, 3'($urandom), 1'b1, 3'($urandom));
        fs_cnt = 0; vs_cnt = 0; first_h = -1; first_v = -1;
        for (int k = 0; k < 340; k++) begin
            int ph, pv;
            ph = mh[1]; pv = mv[1];
            step(1'b0, 3'($urandom), 1'b0, 3'($urandom));
            if (fs_1) fs_cnt++;
            if (vs_1) begin
                vs_cnt++;
                if (first_h < 0) begin first_h = ph; first_v = pv; end
            end
        end
        check("frame_fs_count", 32'(fs_cnt), 32'd2);
        check("frame_vs_width", 32'(vs_cnt), 32'd68);
        check("frame_vs_first_h", 32'(first_h), 32'd0);
        check("frame_vs_first_v", 32'(first_v), 32'd7);

        // Blanking: constant white source over one full frame.
        n111 = 0; n000 = 0;
        for (int k = 0; k < 170; k++) begin
            step(1'b0, 3'($urandom), 1'b0, 3'b111);
            if ({r_1, g_1, b_1} == 3'b111) n111++;
            if ({r_1, g_1, b_1} == 3'b000) n000++;
        end
        check("blank_white", 32'(n111), 32'd60);
        check("blank_black", 32'(n000), 32'd110);

        // Reset while both syncs are about to assert.
        run_to(1, 12, 7);
        step(1'b0, 3'($urandom), 1'b1, 3'($urandom));
        check("mid_rst_addr1", 32'(addr_1), 32'h0020_0000);
        check("mid_rst_hs1", 32'(hs_1), 32'd0);
        check("mid_rst_vs1", 32'(vs_1), 32'd0);
        run_to(0, 900, 3);
        step(1'b1, 3'($urandom), 1'b0, 3'($urandom));
        check("mid_rst_addr0", 32'(addr_0), 32'h0020_0000);
        check("mid_rst_hs0", 32'(hs_0), 32'd0);
        step(1'b0, 3'($urandom), 1'b0, 3'($urandom));
        check("mid_rst_fs0", 32'(fs_0), 32'd1);

        // Random data and sporadic resets against the model.
        rr0_en = 1'b1;
        rr1_en = 1'b1;
        for (int k = 0; k < 3000; k++) rand_step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_scan_controller.md
VGA_SCAN_CONTROLLER -- requirements
Module: vga_scan_controller

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 800, meaning active pixels per line.
REQ-002 SHALL have parameters H_FRONT 56, H_SYNC 120, H_BACK 64, meaning horizontal porch and sync widths in clocks; line total 1040.
REQ-003 SHALL have parameters V_VISIBLE 600, V_FRONT 37, V_SYNC 6, V_BACK 23, meaning vertical geometry in lines; frame total 666.
REQ-004 SHALL have port sysclk, input, 1, meaning the only clock; one pixel per rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-006 SHALL have port display_data, input, 3, meaning {R,G,B} pixel returned combinationally by the pixel source for the current display_addr.
REQ-007 SHALL have port display_addr, output, 22, meaning the scan position: [21] video_active, [20] 0, [19:10] h_count[9:0], [9:0] v_count[9:0].
REQ-008 SHALL have ports vga_r, vga_g, vga_b, output, 1 each, meaning the registered colour bits.
REQ-009 SHALL have ports vga_hsync and vga_vsync, output, 1 each, meaning sync pulses, both active-high.
REQ-010 SHALL have port frame_start, output, 1, meaning a one-clock pulse aligned with the colour output of pixel (0,0).

Function
REQ-011 SHALL keep h_count (11 bit) incrementing every clock over 0..1039 and wrapping 1039->0.
REQ-012 SHALL increment v_count (10 bit) only on the clock where h_count wraps; v_count SHALL wrap 665->0 on that same clock.
REQ-013 SHALL drive display_addr combinationally from the current counters; for h_count>=1024, [19:10] carries h_count[9:0], and video_active is 0 there.
REQ-014 SHALL compute video_active = (h_count<H_VISIBLE) and (v_count<V_VISIBLE).
REQ-015 SHALL compute hsync_c = 1 for h_count in [856,975] and vsync_c = 1 for v_count in [637,642], with bounds derived from the parameters.
REQ-016 SHALL register, on every clock edge, {vga_r,vga_g,vga_b} <= video_active ? display_data : 3'b000, vga_hsync <= hsync_c, vga_vsync <= vsync_c.
REQ-017 Colour, sync and frame_start SHALL have exactly one clock of latency from display_addr.
REQ-018 SHALL register frame_start <= (h_count==0 and v_count==0).
REQ-019 Colour SHALL be 000 whenever the corresponding address was outside the active area, regardless of display_data.

Reset
REQ-020 While rst=1 at a clock edge, the block SHALL set h_count=0, v_count=0, all colour bits=0, vga_hsync=0, vga_vsync=0 and frame_start=0.
REQ-021 Reset asserted mid-line or mid-frame SHALL abandon the scan; the first clock after rst is released SHALL present display_addr for (0,0) with video_active=1.
REQ-022 frame_start SHALL pulse on the second clock after rst is released.

Structure
REQ-023 The timing defaults and the display_addr field positions SHALL live in a shared package or constants file, used by both this block and the pixel source.
REQ-024 One sub-module is natural: vga_axis_counter, instantiated once per axis. It SHALL provide count, wrap pulse, active flag and sync flag, with an increment-enable input.

Verification
REQ-025 Verify reset: hold rst for 3 clocks and release -> display_addr=22'h200000 (active, x=0, y=0); frame_start=1 exactly one clock later.
REQ-026 Verify the horizontal wrap: observe 1040 consecutive clocks -> h_count returns to 0, v_count increments by 1, and vga_hsync is high for exactly 120 clocks, first high one clock after h_count=856.
REQ-027 Verify the frame: run 692,640 clocks (1040x666) from reset -> exactly one frame_start per frame, and vga_vsync is high for 6x1040 clocks beginning one clock after v_count=637, h_count=0.
REQ-028 Verify blanking: tie display_data=3'b111 -> rgb=111 one clock after each address with h<800 and v<600, and rgb=000 one clock after h=800..1039 or v=600..665.
REQ-029 Verify latency: drive display_data = {h_count[0], v_count[0], 1} -> for address (5,3), rgb=3'b111 on the following clock.
REQ-030 Verify reset mid-frame: assert rst at h=400, v=300 for 1 clock -> the next display_addr is (0,0) and vga_hsync/vga_vsync are 0 on the clock after the reset edge.
